// File: rtl/btn_pkg.sv
// Shared defaults for the push-button conditioner.
// The values assume a 100 MHz system clock.
package btn_pkg;

    localparam int unsigned BTN_DEBOUNCE_100M = 1000000;
    localparam int unsigned BTN_LONG_100M     = 100000000;
    localparam int unsigned BTN_CNT_W         = 32;

endpackage

// File: rtl/btn_channel.sv
// One button channel: two-flop synchroniser, debounce, edge pulses and long-press pulse.
// Every output is registered, so there is no combinational path from i_btn.
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = BTN_DEBOUNCE_100M,
    parameter int unsigned LONG_CYC     = BTN_LONG_100M,
    parameter int unsigned CNT_W        = BTN_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYC);

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_press;
    logic             r_release;
    logic             r_long;

    logic w_differs;
    logic w_accept;

    always_comb begin
        w_differs = (r_s2 != r_stable);
        w_accept  = w_differs && (r_db_cnt == DB_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_stable   <= 1'b0;
            r_db_cnt   <= '0;
            r_hold_cnt <= '0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;

            if (!w_differs || w_accept) begin
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + CNT_W'(1);
            end

            if (w_accept) begin
                r_stable <= r_s2;
            end

            // Pulses are registered on the accepting edge, so they coincide with the new level.
            r_press   <= w_accept && r_s2;
            r_release <= w_accept && !r_s2;

            if (w_accept) begin
                r_hold_cnt <= '0;
            end else if (r_stable && (r_hold_cnt < LONG_MAX)) begin
                r_hold_cnt <= r_hold_cnt + CNT_W'(1);
            end

            r_long <= !w_accept && r_stable && (r_hold_cnt == LONG_LAST);
        end
    end

    always_comb begin
        o_level   = r_stable;
        o_press   = r_press;
        o_release = r_release;
        o_long    = r_long;
    end

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: NBTN independent copies of btn_channel.
// Bit i of every output belongs to btn_in[i].
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned NBTN         = 4,
    parameter int unsigned DEBOUNCE_CYC = BTN_DEBOUNCE_100M,
    parameter int unsigned LONG_CYC     = BTN_LONG_100M,
    parameter int unsigned CNT_W        = BTN_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] btn_in,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_release,
    output logic [NBTN-1:0] btn_long
);

    for (genvar g = 0; g < NBTN; g++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC),
            .CNT_W        (CNT_W)
        ) u_channel (
            .clk       (clk),
            .rst       (rst),
            .i_btn     (btn_in[g]),
            .o_level   (btn_level[g]),
            .o_press   (btn_press[g]),
            .o_release (btn_release[g]),
            .o_long    (btn_long[g])
        );
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Multi-channel push-button conditioner. Synchronises raw board buttons, debounces them, and emits a clean level plus one-cycle press, release and long-press pulses. It sits between the board pins and the running-LED/pattern blocks, supplying their reset, step, direction and mode controls.

## Interface
- NBTN, 4, number of button channels (≥1)
- DEBOUNCE_CYC, 1000000, consecutive stable cycles required to accept a new level (10 ms @ 100 MHz; ≥2)
- LONG_CYC, 100000000, hold cycles after press before a long-press pulse (1 s @ 100 MHz; ≥1)
- CNT_W, 32, width of the per-channel counters; must hold max(DEBOUNCE_CYC, LONG_CYC)

- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- btn_in  in  NBTN  raw asynchronous button inputs, active-high
- btn_level  out  NBTN  debounced level
- btn_press  out  NBTN  one-cycle pulse on debounced 0→1
- btn_release  out  NBTN  one-cycle pulse on debounced 1→0
- btn_long  out  NBTN  one-cycle pulse, at most once per press

## Operation
- Channels are fully independent and identical; bit i of every output belongs to btn_in[i].
- Sync: two-flop synchroniser s1→s2, both reset to 0. Only s2 is used downstream.
- Debounce: stable register (drives btn_level) and db_cnt.
  - s2 == stable: db_cnt ← 0.
  - s2 != stable and db_cnt == DEBOUNCE_CYC−1: stable ← s2, db_cnt ← 0.
  - s2 != stable otherwise: db_cnt ← db_cnt+1.
  - Any bounce that returns s2 to stable before acceptance clears db_cnt; no output activity.
- Edge pulses: btn_press and btn_release are registered and high in exactly the first cycle in which btn_level shows its new value.
- Long press: hold_cnt cleared on press; increments each cycle while btn_level = 1 and hold_cnt < LONG_CYC; btn_long asserted in the cycle in which hold_cnt reaches LONG_CYC; it then saturates, so there is no repeat. Release clears hold_cnt. Release before the threshold produces no btn_long.
- Width rule: counters are CNT_W bits unsigned; comparisons are equality against parameter−1 or the parameter, so no wrap-around ever occurs.

## Timing
- Reset values: btn_level, btn_press, btn_release, btn_long all 0; s1, s2, db_cnt, hold_cnt all 0.
- Latency: raw change sampled at edge 1 → btn_level/btn_press (or btn_release) at edge DEBOUNCE_CYC+2.
- btn_long: exactly LONG_CYC cycles after the btn_press cycle, provided btn_level stays 1 through that cycle.
- Pulses are never asserted in the same cycle for the same channel. press/release alternate strictly.
- Reset mid-operation: all state cleared in the cycle after rst is sampled high, including pending pulses. A button held through reset is treated as a new press: btn_press follows DEBOUNCE_CYC+2 cycles after rst deasserts.
- No combinational path from btn_in to any output.

## Structure
- Shared package btn_pkg: default constants BTN_DEBOUNCE_100M = 1000000, BTN_LONG_100M = 100000000, BTN_CNT_W = 32.
- Sub-module btn_channel: one channel (sync, debounce, edge, long-press). btn_conditioner is a generate loop over NBTN instances.

## Test plan
Bench parameters: NBTN = 4, DEBOUNCE_CYC = 4, LONG_CYC = 16.
- Reset: hold rst 3 cycles with btn_in = 4'b1111 → all outputs 0 during reset; btn_press = 4'b1111 exactly 6 cycles after rst falls.
- Clean press on btn_in[0] sampled at edge 1 → btn_level[0] and btn_press[0] at edge 6; press is a single-cycle pulse; other bits stay 0.
- Bounce: btn_in[1] toggles 1,0,1,0 at 2-cycle intervals then returns to 0 → btn_level[1] never rises; no pulses.
- Long press: btn_in[2] held 40 cycles → press at t, btn_long[2] only at t+16; release gives btn_release[2] 6 cycles after the input falls.
- Short press: btn_in[3] held 10 cycles → press and release pulses only; no btn_long[3].
- Mid-operation reset: rst pulsed at hold_cnt = 8 on channel 0 with the button held → no btn_long; a new btn_press occurs 6 cycles after rst falls, and btn_long occurs 16 cycles after that.
